add_pipe: RTL and testbench
===========================

# add_pipe

Parametrised, pipelined two's-complement adder/subtractor with carry-in, carry-out and signed-overflow flags. The carry chain is cut into fixed-width segments, with one register stage per segment. This gives one result per clock at higher frequency than a 16-bit ripple adder. It sits between an operand-issuing datapath and a result consumer, and uses a valid/ready handshake with full backpressure.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of SEG and at least 2
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG, at least 1
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = add, 1 = subtract
- cin  input  1  carry-in (add) / borrow-in (subtract)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  result
- carry  output  1  raw carry out of bit WIDTH-1
- overflow  output  1  signed overflow

## Operation
- Effective computation: out = a + (b XOR {WIDTH{sub}}) + (cin XOR sub), truncated to WIDTH bits.
  - sub=0, cin=0 gives a+b.
  - sub=1, cin=0 gives a-b.
  - sub=1, cin=1 gives a-b-1.
- carry = bit WIDTH of the full sum (the raw carry, so for subtraction carry=1 means no borrow).
- overflow = carry into MSB XOR carry out of MSB. Equivalently: both effective operands have the same sign and the result sign differs.
- Stage k (0..STAGES-1) resolves bits [k*SEG +: SEG] using the carry registered by stage k-1; stage 0 uses cin XOR sub.
- Operand bits not yet consumed are carried forward in skew registers. Already-computed result bits are carried forward alongside them.
- Each stage holds a valid bit. The transfer is a single global advance = !out_valid || out_ready.
  - When advance is high, every stage shifts by one: stage 0 loads (in_valid && in_ready) and the inputs, and the last stage drives out/carry/overflow/out_valid.
  - When advance is low, all stage registers hold.
- in_ready = advance (combinational). Bubbles are not compressed, but throughput is one result per cycle when out_ready stays high.
- Results emerge strictly in acceptance order; there is no loss and no duplication.

## Timing
- Accept: in_valid && in_ready at edge N.
- Result: out_valid=1 after edge N+STAGES-1 when there is no stall. The result is registered, so latency is STAGES cycles from acceptance to out_valid with no back-pressure.
- out/carry/overflow are stable while out_valid && !out_ready.
- A result is consumed at the edge where out_valid && out_ready. It is replaced in the same edge if a successor is ready.
- Simultaneous pop and push with the pipeline full is legal and keeps full throughput.
- Reset (asynchronous assertion):
  - all stage valid bits, out_valid, out, carry and overflow go to 0 immediately;
  - all in-flight operations are discarded;
  - in_ready reads 1 after reset, but inputs are not captured while reset is high.
- Reset release mid-stream: the first accepted operation after release emerges after STAGES cycles, and no stale result appears.
- Inputs a/b/sub/cin are don't-care when in_valid=0. A stage whose valid bit is 0 never raises out_valid.
- STAGES=1: behaves as a single registered adder with latency 1.

## Test plan
All scenarios use WIDTH=16, SEG=4 (latency 4) unless noted.
- Add: a=0x00FF, b=0x0001, sub=0, cin=0, out_ready=1 -> 4 cycles later out=0x0100, carry=0, overflow=0, out_valid pulses for 1 cycle.
- Carry through all segments: 0xFFFF+0x0001 -> out=0x0000, carry=1, overflow=0. Also 0x7FFF+0x0001 -> 0x8000, carry=0, overflow=1.
- Subtract:
  - 0x0005-0x0007 -> 0xFFFE, carry=0, overflow=0.
  - 0x8000-0x0001 -> 0x7FFF, carry=1, overflow=1.
  - cin=1 with 0x0010-0x0001 -> 0x000E.
- Backpressure: stream 8 random operand pairs back-to-back and drop out_ready for 3 cycles mid-stream.
  - in_ready falls in exactly those cycles.
  - All 8 results match the reference model in order, with none lost or duplicated.
  - out is held stable during the stall.
- Reset mid-operation: accept 3 operations, assert reset before the first result.
  - out_valid=0 immediately and stays 0.
  - After release, one new add 0x1234+0x1111 yields only 0x2345 after 4 cycles.
- Parameter sweep: WIDTH=8/SEG=8 (latency 1) and WIDTH=32/SEG=4 (latency 8), using 1000 random operations with random sub/cin/out_ready -> every result, carry and overflow matches the model.

Source files
------------

// File: rtl/add_pipe.sv
`timescale 1ns/1ps
// Pipelined two's-complement add/sub with carry and overflow. Each stage resolves one SEG-bit segment, so latency is WIDTH/SEG cycles.
// A single global advance holds every stage while a result waits on out_ready, so in_ready = !out_valid || out_ready.
module add_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow
);
    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    logic advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand skew shrinks by one segment per stage; the resolved result grows by one.
        localparam int SRC = WIDTH - k * SEG;
        localparam int RES = (k + 1) * SEG;

        logic           vld_d;
        logic           cy_in;
        logic [SRC-1:0] src_a;
        logic [SRC-1:0] src_b;
        logic [SEG:0]   seg_sum;
        logic [RES-1:0] res_d;
        logic           vld_q;
        logic           cy_q;
        logic [RES-1:0] res_q;

        if (k == 0) begin : g_head
            assign vld_d = in_valid;
            assign src_a = a;
            assign src_b = b ^ {WIDTH{sub}};
            assign cy_in = cin ^ sub;
            assign res_d = seg_sum[SEG-1:0];
        end else begin : g_body
            assign vld_d = g_stage[k-1].vld_q;
            assign src_a = g_stage[k-1].g_skew.opa_q;
            assign src_b = g_stage[k-1].g_skew.opb_q;
            assign cy_in = g_stage[k-1].cy_q;
            assign res_d = {seg_sum[SEG-1:0], g_stage[k-1].res_q};
        end

        assign seg_sum = {1'b0, src_a[SEG-1:0]} + {1'b0, src_b[SEG-1:0]} + {{SEG{1'b0}}, cy_in};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                res_q <= '0;
            end else if (advance) begin
                vld_q <= vld_d;
                cy_q  <= seg_sum[SEG];
                res_q <= res_d;
            end
        end

        if (k < LAST) begin : g_skew
            logic [SRC-SEG-1:0] opa_q;
            logic [SRC-SEG-1:0] opb_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (advance) begin
                    opa_q <= src_a[SRC-1:SEG];
                    opb_q <= src_b[SRC-1:SEG];
                end
            end
        end else begin : g_tail
            logic ovf_q;

            // Carry into the MSB is recovered as a^b^sum at that bit position.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= src_a[SEG-1] ^ src_b[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
                end
            end
        end
    end

    assign out_valid = g_stage[LAST].vld_q;
    assign out       = g_stage[LAST].res_q;
    assign carry     = g_stage[LAST].cy_q;
    assign overflow  = g_stage[LAST].g_tail.ovf_q;
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

endmodule

// File: tb/tb_add_pipe.sv
`timescale 1ns/1ps
// Bench for add_pipe: directed vectors, backpressure, mid-stream reset and a random sweep of three widths.
module tb_add_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        m_iv, m_ir, m_sub, m_cin, m_ov, m_or, m_c, m_v;
    logic [15:0] m_a, m_b, m_out;
    logic        s8_iv, s8_ir, s8_sub, s8_cin, s8_ov, s8_or, s8_c, s8_v;
    logic [7:0]  s8_a, s8_b, s8_out;
    logic        s32_iv, s32_ir, s32_sub, s32_cin, s32_ov, s32_or, s32_c, s32_v;
    logic [31:0] s32_a, s32_b, s32_out;

    add_pipe #(.WIDTH(16), .SEG(4)) u_m (
        .clk(clk), .reset(rst), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
        .sub(m_sub), .cin(m_cin), .out_valid(m_ov), .out_ready(m_or), .out(m_out),
        .carry(m_c), .overflow(m_v));

    add_pipe #(.WIDTH(8), .SEG(8)) u_s8 (
        .clk(clk), .reset(rst), .in_valid(s8_iv), .in_ready(s8_ir), .a(s8_a), .b(s8_b),
        .sub(s8_sub), .cin(s8_cin), .out_valid(s8_ov), .out_ready(s8_or), .out(s8_out),
        .carry(s8_c), .overflow(s8_v));

    add_pipe #(.WIDTH(32), .SEG(4)) u_s32 (
        .clk(clk), .reset(rst), .in_valid(s32_iv), .in_ready(s32_ir), .a(s32_a), .b(s32_b),
        .sub(s32_sub), .cin(s32_cin), .out_valid(s32_ov), .out_ready(s32_or), .out(s32_out),
        .carry(s32_c), .overflow(s32_v));

    int checks = 0;
    int errors = 0;
    int n_push, n_pop, n8, n32, p8, p32;
    logic [15:0] held;
    logic [33:0] m_q[$];
    logic [33:0] q8[$];
    logic [33:0] q32[$];

    // Reference: {overflow, carry, out[31:0]} from unbounded integer arithmetic.
    function automatic logic [33:0] model(int w, longint unsigned a, longint unsigned b, bit sub, bit cin);
        longint unsigned mask, am, beff, full;
        longint sa, sb, sr, smax, smin;
        logic [31:0] o;
        logic c, v;
        mask = (64'd1 << w) - 1;
        am   = a & mask;
        beff = sub ? (~b & mask) : (b & mask);
        full = am + beff + longint'(cin ^ sub);
        o    = 32'(full & mask);
        c    = ((full >> w) & 1) != 0;
        smax = longint'((64'd1 << (w - 1)) - 1);
        smin = -smax - 1;
        sa   = (am > 64'(smax)) ? longint'(am) - longint'(64'd1 << w) : longint'(am);
        sb   = (beff > 64'(smax)) ? longint'(beff) - longint'(64'd1 << w) : longint'(beff);
        sr   = sa + sb + longint'(cin ^ sub);
        v    = (sr > smax) || (sr < smin);
        return {v, c, o};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 16-bit DUT: drive at negedge, settle, then score the handshakes of the next edge.
    task automatic m_cycle(input bit iv, input bit ordy);
        logic [33:0] e;
        @(negedge clk);
        m_iv  = iv;
        m_or  = ordy;
        m_a   = 16'($urandom);
        m_b   = 16'($urandom);
        m_sub = 1'($urandom_range(0, 1));
        m_cin = 1'($urandom_range(0, 1));
        #1;
        if (m_ov && m_or) begin
            if (m_q.size() == 0) begin
                check("m_extra_result", 64'(m_q.size()), 64'd1);
            end else begin
                e = m_q.pop_front();
                check("m_out", 64'(m_out), 64'(e[15:0]));
                check("m_carry", 64'(m_c), 64'(e[32]));
                check("m_ovf", 64'(m_v), 64'(e[33]));
                n_pop++;
            end
        end
        if (m_iv && m_ir) begin
            m_q.push_back(model(16, 64'(m_a), 64'(m_b), m_sub, m_cin));
            n_push++;
        end
    endtask

    task automatic directed(string tag, logic [15:0] a, logic [15:0] b, logic sub, logic cin,
                            logic [15:0] eo, logic ec, logic ev);
        int lat;
        @(negedge clk);
        m_iv = 1'b1; m_a = a; m_b = b; m_sub = sub; m_cin = cin; m_or = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(m_ir), 64'd1);
        @(negedge clk);
        m_iv = 1'b0;
        lat  = 1;
        while (!m_ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_out"}, 64'(m_out), 64'(eo));
        check({tag, "_carry"}, 64'(m_c), 64'(ec));
        check({tag, "_ovf"}, 64'(m_v), 64'(ev));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(m_ov), 64'd0);
    endtask

    task automatic s_cycle(input bit en8, input bit en32, input bit drain);
        logic [33:0] e;
        @(negedge clk);
        s8_iv   = en8 && ($urandom_range(0, 3) != 0);
        s8_or   = drain || ($urandom_range(0, 3) != 0);
        s8_a    = 8'($urandom);
        s8_b    = 8'($urandom);
        s8_sub  = 1'($urandom_range(0, 1));
        s8_cin  = 1'($urandom_range(0, 1));
        s32_iv  = en32 && ($urandom_range(0, 3) != 0);
        s32_or  = drain || ($urandom_range(0, 3) != 0);
        s32_a   = $urandom;
        s32_b   = $urandom;
        s32_sub = 1'($urandom_range(0, 1));
        s32_cin = 1'($urandom_range(0, 1));
        #1;
        if (s8_ov && s8_or) begin
            if (q8.size() == 0) begin
                check("s8_extra_result", 64'(q8.size()), 64'd1);
            end else begin
                e = q8.pop_front();
                check("s8_out", 64'(s8_out), 64'(e[7:0]));
                check("s8_carry", 64'(s8_c), 64'(e[32]));
                check("s8_ovf", 64'(s8_v), 64'(e[33]));
                p8++;
            end
        end
        if (s32_ov && s32_or) begin
            if (q32.size() == 0) begin
                check("s32_extra_result", 64'(q32.size()), 64'd1);
            end else begin
                e = q32.pop_front();
                check("s32_out", 64'(s32_out), 64'(e[31:0]));
                check("s32_carry", 64'(s32_c), 64'(e[32]));
                check("s32_ovf", 64'(s32_v), 64'(e[33]));
                p32++;
            end
        end
        if (s8_iv && s8_ir) begin
            q8.push_back(model(8, 64'(s8_a), 64'(s8_b), s8_sub, s8_cin));
            n8++;
        end
        if (s32_iv && s32_ir) begin
            q32.push_back(model(32, 64'(s32_a), 64'(s32_b), s32_sub, s32_cin));
            n32++;
        end
    endtask

    initial begin
        rst = 1'b1;
        m_iv = 0; m_a = 0; m_b = 0; m_sub = 0; m_cin = 0; m_or = 1;
        s8_iv = 0; s8_a = 0; s8_b = 0; s8_sub = 0; s8_cin = 0; s8_or = 1;
        s32_iv = 0; s32_a = 0; s32_b = 0; s32_sub = 0; s32_cin = 0; s32_or = 1;
        n_push = 0; n_pop = 0; n8 = 0; n32 = 0; p8 = 0; p32 = 0; held = '0;
        #1;
        check("reset_out_valid", 64'(m_ov), 64'd0);
        check("reset_out", 64'(m_out), 64'd0);
        check("reset_carry", 64'(m_c), 64'd0);
        check("reset_ovf", 64'(m_v), 64'd0);
        check("reset_in_ready", 64'(m_ir), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        directed("add", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        directed("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        directed("sub_cin", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

        // Backpressure: 8 back-to-back operands, out_ready low in cycles 5..7.
        n_push = 0; n_pop = 0;
        for (int c = 0; c < 40 && n_pop < 8; c++) begin
            m_cycle(n_push < 8, !(c >= 5 && c <= 7));
            check("bp_in_ready", 64'(m_ir), 64'(!(c >= 5 && c <= 7)));
            if (c == 5) held = m_out;
            if (c == 6 || c == 7) check("bp_hold", 64'(m_out), 64'(held));
        end
        check("bp_popped", 64'(n_pop), 64'd8);
        check("bp_leftover", 64'(m_q.size()), 64'd0);

        // Random traffic with random stalls on the 16-bit instance, then drain.
        n_push = 0; n_pop = 0;
        for (int c = 0; c < 3000 && n_push < 200; c++)
            m_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        for (int c = 0; c < 50 && m_q.size() != 0; c++) m_cycle(1'b0, 1'b1);
        check("rand_popped", 64'(n_pop), 64'd200);

        // Reset while three operations are in flight.
        repeat (3) m_cycle(1'b1, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(m_ov), 64'd0);
        check("rst_out", 64'(m_out), 64'd0);
        check("rst_carry", 64'(m_c), 64'd0);
        check("rst_ovf", 64'(m_v), 64'd0);
        m_q.delete();
        m_iv = 1'b1; m_a = 16'hDEAD; m_b = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_valid", 64'(m_ov), 64'd0);
            check("rst_in_ready", 64'(m_ir), 64'd1);
        end
        m_iv = 1'b0;
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(m_ov), 64'd0);
        end
        directed("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(m_ov), 64'd0);
        end

        // Parameter sweep: WIDTH=8/SEG=8 and WIDTH=32/SEG=4 with random valid/ready.
        for (int c = 0; c < 20000 && (n8 < 1000 || n32 < 1000); c++)
            s_cycle(n8 < 1000, n32 < 1000, 1'b0);
        for (int c = 0; c < 100 && (q8.size() != 0 || q32.size() != 0); c++)
            s_cycle(1'b0, 1'b0, 1'b1);
        check("s8_popped", 64'(p8), 64'd1000);
        check("s32_popped", 64'(p32), 64'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
